// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared constants and FSM state type for the NCO phase bank
package synth_pkg;
    localparam int VOICES  = 8;
    localparam int ACC_W   = 32;
    localparam int PHASE_W = 16;
    localparam int FLUSH   = 3;
    localparam int VOICE_W = $clog2(VOICES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_FLUSH
    } state_t;
endpackage

// File: rtl/nco_phase_bank_if.sv
// rtl/nco_phase_bank_if.sv - control, voice-write and sine-stage output bundle
interface nco_phase_bank_if #(
    parameter int VOICES  = synth_pkg::VOICES,
    parameter int ACC_W   = synth_pkg::ACC_W,
    parameter int PHASE_W = synth_pkg::PHASE_W
);
    localparam int VW = $clog2(VOICES);

    logic               i_sample_tick;
    logic               i_wr_en;
    logic [VW-1:0]      i_wr_voice;
    logic [ACC_W-1:0]   i_wr_tuning;
    logic               i_wr_gate;
    logic [PHASE_W-1:0] o_phase;
    logic               o_clk_en;
    logic [VW-1:0]      o_voice;
    logic               o_voice_valid;
    logic               o_gate;
    logic               o_overrun;

    modport master (
        output i_sample_tick, i_wr_en, i_wr_voice, i_wr_tuning, i_wr_gate,
        input  o_phase, o_clk_en, o_voice, o_voice_valid, o_gate, o_overrun
    );

    modport slave (
        input  i_sample_tick, i_wr_en, i_wr_voice, i_wr_tuning, i_wr_gate,
        output o_phase, o_clk_en, o_voice, o_voice_valid, o_gate, o_overrun
    );
endinterface

// File: rtl/nco_voice_store.sv
// rtl/nco_voice_store.sv - per-voice accumulator, tuning word and gate storage
module nco_voice_store
    import synth_pkg::*;
#(
    parameter int VOICES = synth_pkg::VOICES,
    parameter int ACC_W  = synth_pkg::ACC_W,
    localparam int VW    = $clog2(VOICES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sweep_en,
    input  logic [VW-1:0]    sweep_voice,
    output logic [ACC_W-1:0] sweep_acc,
    output logic             sweep_gate,
    input  logic             wr_en,
    input  logic [VW-1:0]    wr_voice,
    input  logic [ACC_W-1:0] wr_tuning,
    input  logic             wr_gate
);
    logic [ACC_W-1:0] acc    [VOICES];
    logic [ACC_W-1:0] tuning [VOICES];
    logic [VOICES-1:0] gate;

    assign sweep_acc  = acc[sweep_voice];
    assign sweep_gate = gate[sweep_voice];

    // Accumulate sees the pre-write tuning/gate; a gate-rising clear wins over it.
    always_ff @(posedge clk) begin
        if (reset) begin
            gate <= '0;
            for (int v = 0; v < VOICES; v++) begin
                acc[v]    <= '0;
                tuning[v] <= '0;
            end
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                if (wr_en && wr_voice == VW'(v) && wr_gate && !gate[v])
                    acc[v] <= '0;
                else if (sweep_en && sweep_voice == VW'(v) && gate[v])
                    acc[v] <= acc[v] + tuning[v];
                if (wr_en && wr_voice == VW'(v)) begin
                    tuning[v] <= wr_tuning;
                    gate[v]   <= wr_gate;
                end
            end
        end
    end
endmodule

// File: rtl/nco_phase_bank.sv
// rtl/nco_phase_bank.sv - time-multiplexed polyphonic phase accumulator feeding the sine stage
module nco_phase_bank
    import synth_pkg::*;
#(
    parameter int VOICES  = synth_pkg::VOICES,
    parameter int ACC_W   = synth_pkg::ACC_W,
    parameter int PHASE_W = synth_pkg::PHASE_W,
    parameter int FLUSH   = synth_pkg::FLUSH
) (
    input logic              clk,
    input logic              reset,
    nco_phase_bank_if.slave  bus
);
    localparam int VW      = $clog2(VOICES);
    localparam int CNT_MAX = (VOICES > FLUSH) ? VOICES : FLUSH;
    localparam int CW      = $clog2(CNT_MAX);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [ACC_W-1:0] sweep_acc;
    logic             sweep_gate;

    nco_voice_store #(
        .VOICES (VOICES),
        .ACC_W  (ACC_W)
    ) u_store (
        .clk         (clk),
        .reset       (reset),
        .sweep_en    (state == ST_SWEEP),
        .sweep_voice (cnt[VW-1:0]),
        .sweep_acc   (sweep_acc),
        .sweep_gate  (sweep_gate),
        .wr_en       (bus.i_wr_en),
        .wr_voice    (bus.i_wr_voice),
        .wr_tuning   (bus.i_wr_tuning),
        .wr_gate     (bus.i_wr_gate)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            bus.o_phase       <= '0;
            bus.o_clk_en      <= 1'b0;
            bus.o_voice       <= '0;
            bus.o_voice_valid <= 1'b0;
            bus.o_gate        <= 1'b0;
            bus.o_overrun     <= 1'b0;
        end else begin
            bus.o_phase       <= '0;
            bus.o_clk_en      <= 1'b0;
            bus.o_voice       <= '0;
            bus.o_voice_valid <= 1'b0;
            bus.o_gate        <= 1'b0;
            // Includes the final flush cycle, where the FSM is on its way back to IDLE.
            if (bus.i_sample_tick && state != ST_IDLE)
                bus.o_overrun <= 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (bus.i_sample_tick) begin
                        state <= ST_SWEEP;
                        cnt   <= '0;
                    end
                end
                ST_SWEEP: begin
                    bus.o_clk_en      <= 1'b1;
                    bus.o_voice       <= cnt[VW-1:0];
                    bus.o_voice_valid <= 1'b1;
                    bus.o_gate        <= sweep_gate;
                    bus.o_phase       <= sweep_gate ? sweep_acc[ACC_W-1 -: PHASE_W] : '0;
                    if (cnt == CW'(VOICES - 1)) begin
                        state <= ST_FLUSH;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    bus.o_clk_en <= 1'b1;
                    if (cnt == CW'(FLUSH - 1)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nco_phase_bank.sv
// tb/tb_nco_phase_bank.sv - self-checking bench for nco_phase_bank against a per-edge voice model
module tb_nco_phase_bank;
    import synth_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    nco_phase_bank_if bus();

    nco_phase_bank dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] m_acc [VOICES];
    logic [31:0] m_tun [VOICES];
    bit          m_gate [VOICES];
    bit          m_ovr;
    logic [15:0] last_phase [VOICES];
    logic        last_gate [VOICES];
    int          clk_en_count;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_sample_tick = 1'b0;
        bus.i_wr_en       = 1'b0;
        bus.i_wr_voice    = '0;
        bus.i_wr_tuning   = '0;
        bus.i_wr_gate     = 1'b0;
    endtask

    task automatic model_reset();
        for (int v = 0; v < VOICES; v++) begin
            m_acc[v] = 0; m_tun[v] = 0; m_gate[v] = 0;
        end
        m_ovr = 0;
    endtask

    task automatic model_write(input int v, input logic [31:0] t, input bit g);
        if (g && !m_gate[v]) m_acc[v] = 0;
        m_tun[v] = t;
        m_gate[v] = g;
    endtask

    task automatic do_write(input int v, input logic [31:0] t, input bit g);
        bus.i_wr_en = 1'b1; bus.i_wr_voice = VOICE_W'(v); bus.i_wr_tuning = t; bus.i_wr_gate = g;
        step();
        model_write(v, t, g);
        idle_inputs();
    endtask

    // Tick at edge T, then walk edges T+1..T+VOICES+FLUSH+1 comparing every output.
    // ovr_at / wr_at (offset from T, -1 = none) inject a stray tick or a write at that edge.
    task automatic run_sweep(input int ovr_at, input int wr_at, input int wr_v,
                             input logic [31:0] wr_t, input bit wr_g);
        logic [15:0] exp_ph;
        bus.i_sample_tick = 1'b1;
        step();
        bus.i_sample_tick = 1'b0;
        clk_en_count = 0;
        for (int k = 1; k <= VOICES + FLUSH + 1; k++) begin
            bus.i_sample_tick = (k == ovr_at);
            if (k == wr_at) begin
                bus.i_wr_en = 1'b1; bus.i_wr_voice = VOICE_W'(wr_v);
                bus.i_wr_tuning = wr_t; bus.i_wr_gate = wr_g;
            end else begin
                bus.i_wr_en = 1'b0;
            end
            step();
            if (k == ovr_at) m_ovr = 1;
            if (bus.o_clk_en) clk_en_count++;
            if (k <= VOICES) begin
                int v = k - 1;
                exp_ph = m_gate[v] ? m_acc[v][31:16] : 16'h0;
                checks++; if (bus.o_phase !== exp_ph) begin failures++; $display("FAIL sweep_phase v%0d got=%h exp=%h", v, bus.o_phase, exp_ph); end
                checks++; if (bus.o_voice !== VOICE_W'(v)) begin failures++; $display("FAIL sweep_voice k%0d got=%0d exp=%0d", k, bus.o_voice, v); end
                checks++; if (bus.o_voice_valid !== 1'b1) begin failures++; $display("FAIL sweep_valid v%0d got=%b exp=1", v, bus.o_voice_valid); end
                checks++; if (bus.o_gate !== m_gate[v]) begin failures++; $display("FAIL sweep_gate v%0d got=%b exp=%b", v, bus.o_gate, m_gate[v]); end
                checks++; if (bus.o_clk_en !== 1'b1) begin failures++; $display("FAIL sweep_clk_en v%0d got=%b exp=1", v, bus.o_clk_en); end
                last_phase[v] = bus.o_phase;
                last_gate[v]  = bus.o_gate;
                if (m_gate[v]) m_acc[v] = m_acc[v] + m_tun[v];
            end else if (k <= VOICES + FLUSH) begin
                checks++; if (bus.o_clk_en !== 1'b1 || bus.o_voice_valid !== 1'b0 || bus.o_phase !== 16'h0 ||
                              bus.o_voice !== '0 || bus.o_gate !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_outputs k%0d got clk_en=%b valid=%b phase=%h voice=%0d gate=%b exp 1 0 0000 0 0",
                             k, bus.o_clk_en, bus.o_voice_valid, bus.o_phase, bus.o_voice, bus.o_gate);
                end
            end else begin
                checks++; if (bus.o_clk_en !== 1'b0 || bus.o_voice_valid !== 1'b0 || bus.o_phase !== 16'h0) begin
                    failures++;
                    $display("FAIL idle_after_sweep got clk_en=%b valid=%b phase=%h exp 0 0 0000",
                             bus.o_clk_en, bus.o_voice_valid, bus.o_phase);
                end
            end
            if (k == wr_at) model_write(wr_v, wr_t, wr_g);
            checks++; if (bus.o_overrun !== m_ovr) begin failures++; $display("FAIL overrun k%0d got=%b exp=%b", k, bus.o_overrun, m_ovr); end
        end
        idle_inputs();
        checks++; if (clk_en_count != VOICES + FLUSH) begin failures++; $display("FAIL clk_en_count got=%0d exp=%0d", clk_en_count, VOICES + FLUSH); end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (bus.o_phase !== 16'h0 || bus.o_clk_en !== 1'b0 || bus.o_voice !== '0 ||
            bus.o_voice_valid !== 1'b0 || bus.o_gate !== 1'b0 || bus.o_overrun !== 1'b0) begin
            failures++;
            $display("FAIL %s got phase=%h clk_en=%b voice=%0d valid=%b gate=%b overrun=%b exp all 0",
                     tag, bus.o_phase, bus.o_clk_en, bus.o_voice, bus.o_voice_valid, bus.o_gate, bus.o_overrun);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        model_reset();
        check_all_zero("reset_state");
        step();
        check_all_zero("idle_no_tick");
    endtask

    task automatic test_basic();
        logic [15:0] exp_seq [4] = '{16'h0000, 16'h0100, 16'h0200, 16'h0300};
        do_write(0, 32'h0100_0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_sweep(-1, -1, 0, 0, 0);
            checks++; if (last_phase[0] !== exp_seq[i]) begin failures++; $display("FAIL basic_v0 sweep%0d got=%h exp=%h", i, last_phase[0], exp_seq[i]); end
            repeat (3) step();
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_seq [3] = '{16'h0000, 16'h8000, 16'h0000};
        do_write(3, 32'h8000_0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            run_sweep(-1, -1, 0, 0, 0);
            checks++; if (last_phase[3] !== exp_seq[i]) begin failures++; $display("FAIL wrap_v3 sweep%0d got=%h exp=%h", i, last_phase[3], exp_seq[i]); end
        end
    endtask

    task automatic test_gate_restart();
        do_write(2, 32'h0400_0000, 1'b1);
        run_sweep(-1, -1, 0, 0, 0);
        run_sweep(-1, -1, 0, 0, 0);
        do_write(2, 32'h0400_0000, 1'b0);
        run_sweep(-1, -1, 0, 0, 0);
        checks++; if (last_phase[2] !== 16'h0 || last_gate[2] !== 1'b0) begin failures++; $display("FAIL gate_off_v2 got phase=%h gate=%b exp 0000 0", last_phase[2], last_gate[2]); end
        do_write(2, 32'h0400_0000, 1'b1);
        run_sweep(-1, -1, 0, 0, 0);
        checks++; if (last_phase[2] !== 16'h0000) begin failures++; $display("FAIL gate_restart_v2 got=%h exp=0000", last_phase[2]); end
        run_sweep(-1, -1, 0, 0, 0);
        checks++; if (last_phase[2] !== 16'h0400) begin failures++; $display("FAIL gate_advance_v2 got=%h exp=0400", last_phase[2]); end
    endtask

    task automatic test_collision();
        logic [15:0] exp_seq [3] = '{16'h0000, 16'h0100, 16'h0300};
        do_write(1, 32'h0100_0000, 1'b1);
        run_sweep(-1, 2, 1, 32'h0200_0000, 1'b1);
        checks++; if (last_phase[1] !== exp_seq[0]) begin failures++; $display("FAIL collision_v1 sweep0 got=%h exp=%h", last_phase[1], exp_seq[0]); end
        for (int i = 1; i < 3; i++) begin
            run_sweep(-1, -1, 0, 0, 0);
            checks++; if (last_phase[1] !== exp_seq[i]) begin failures++; $display("FAIL collision_v1 sweep%0d got=%h exp=%h", i, last_phase[1], exp_seq[i]); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            int nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++)
                do_write($urandom_range(0, VOICES - 1), $urandom, 1'($urandom_range(0, 1)));
            run_sweep(-1, $urandom_range(1, VOICES + FLUSH), $urandom_range(0, VOICES - 1),
                      $urandom, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_overrun();
        run_sweep(5, -1, 0, 0, 0);
        step();
        checks++; if (bus.o_overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b exp=1", bus.o_overrun); end
    endtask

    task automatic test_reset_mid();
        bus.i_sample_tick = 1'b1;
        step();
        bus.i_sample_tick = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        check_all_zero("reset_mid_sweep");
        for (int i = 0; i < 6; i++) begin
            step();
            check_all_zero("after_reset_abort");
        end
        run_sweep(-1, -1, 0, 0, 0);
        checks++; if (last_phase[0] !== 16'h0 || last_gate[0] !== 1'b0) begin failures++; $display("FAIL post_reset_v0 got phase=%h gate=%b exp 0000 0", last_phase[0], last_gate[0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_gate_restart();
        test_collision();
        test_random();
        test_overrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nco_phase_bank.md
# nco_phase_bank

Time-multiplexed polyphonic phase accumulator: one 32-bit phase accumulator and tuning word per voice, swept once per audio sample. Sits directly upstream of the quarter-wave sine stage. It emits one 16-bit phase per voice together with the clock-enable strobe that advances that stage. After the voices, it emits flush strobes so the sine stage's 3-deep pipeline drains within the same sample period.

## Interface

Parameters:
- VOICES, 8, number of voices (power of two, ≥2)
- ACC_W, 32, accumulator and tuning-word width
- PHASE_W, 16, output phase width (top bits of accumulator)
- FLUSH, 3, trailing strobes per sweep (matches sine stage latency)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_sample_tick  in  1  one-cycle pulse at sample rate; starts a sweep
- i_wr_en  in  1  voice-register write strobe
- i_wr_voice  in  log2(VOICES)  voice addressed by the write
- i_wr_tuning  in  ACC_W  tuning word (phase increment per sample)
- i_wr_gate  in  1  gate value written with the tuning word
- o_phase  out  PHASE_W  phase for the sine stage
- o_clk_en  out  1  strobe; high on every sweep and flush cycle
- o_voice  out  log2(VOICES)  voice index of o_phase
- o_voice_valid  out  1  high on voice cycles, low on flush cycles
- o_gate  out  1  gate of the voice on o_voice
- o_overrun  out  1  sticky; set when a tick arrives outside IDLE

## Operation

- States: IDLE, SWEEP, FLUSH.
  - IDLE -> SWEEP on i_sample_tick; voice counter cleared.
  - SWEEP holds for VOICES cycles; the counter increments each cycle. Leaves to FLUSH after the voice VOICES-1 cycle.
  - FLUSH holds for FLUSH cycles, then returns to IDLE.
- SWEEP cycle for voice v:
  - If gate[v]=1: o_phase = acc[v][ACC_W-1 -: PHASE_W] (pre-increment value), and acc[v] <= acc[v] + tuning[v], modulo 2^ACC_W (natural wrap, no saturation).
  - If gate[v]=0: o_phase = 0 and acc[v] is unchanged.
  - In both cases o_gate = gate[v] and o_voice_valid = 1.
- FLUSH cycle: o_clk_en = 1, o_voice_valid = 0, o_phase = 0, o_voice = 0, o_gate = 0.
- IDLE: o_clk_en = 0. o_phase, o_voice, o_voice_valid and o_gate hold 0.
- Write (i_wr_en, accepted in any state):
  - tuning[i_wr_voice] <= i_wr_tuning and gate[i_wr_voice] <= i_wr_gate.
  - Gate rising edge (0 -> 1) clears acc[i_wr_voice] to 0, so the note starts at phase 0.
  - A write of gate 0 leaves acc unchanged.
- Collision (write to the voice being swept in the same cycle):
  - The accumulate uses the old tuning and old gate.
  - The new tuning and gate take effect from the next sweep.
  - A gate-rising clear beats the accumulate: acc = 0 after the cycle.
- i_sample_tick while in SWEEP/FLUSH: tick dropped, o_overrun <= 1. o_overrun is cleared only by reset.
- Tick in the same cycle the FSM returns from FLUSH to IDLE counts as an overrun.

## Timing

- Tick sampled in IDLE at cycle T:
  - Voice v is presented (registered) at cycle T+1+v, for v = 0..VOICES-1.
  - Flush strobes at T+1+VOICES .. T+VOICES+FLUSH.
  - IDLE again at T+VOICES+FLUSH+1; the earliest accepted next tick is that cycle.
- All outputs are registered. o_clk_en is contiguous for VOICES+FLUSH cycles per sweep.
- Accumulator update is visible on the next sweep; a write is visible from the next sweep.
- Reset (any state, including mid-sweep):
  - Next cycle: state IDLE; all acc, tuning and gate cleared to 0.
  - All outputs 0, including o_overrun.
  - No further strobes from an aborted sweep.

## Structure

- Shared package synth_pkg:
  - VOICES, ACC_W, PHASE_W, FLUSH constants
  - voice index width: $clog2(VOICES)
  - state enum (IDLE/SWEEP/FLUSH)
- One sub-module: nco_voice_store.
  - Per-voice acc/tuning/gate storage.
  - One read-modify-write port for the sweep and one write port for i_wr_*.
  - Collision priority as defined under Operation.
- The FSM, counters and output registers live in nco_phase_bank.

## Test plan

- Voice 0 write tuning 0x0100_0000, gate 1; 4 ticks spaced 16 cycles apart:
  - voice-0 o_phase = 0x0000, 0x0100, 0x0200, 0x0300.
  - Each sweep gives exactly 11 o_clk_en cycles: 8 valid, 3 flush.
- Voice 3 tuning 0x8000_0000, gate 1; 3 ticks -> voice-3 o_phase = 0x0000, 0x8000, 0x0000 (wrap, no saturation).
- Voice 2 gate 1 with tuning 0x0400_0000 over 2 ticks (acc reaches 0x0800_0000), then write gate 0, then gate 1:
  - Gate 0: o_phase = 0 and o_gate = 0 on voice 2.
  - Gate 1 again: o_phase restarts at 0x0000.
- Tick at T, second tick at T+5: o_overrun = 1 from T+6; sweep still ends at T+11, with no extra strobes.
- Write voice 1 tuning 0x0200_0000 in the exact cycle voice 1 is swept (old tuning 0x0100_0000, acc 0):
  - Phases on successive sweeps: 0x0000, 0x0100, 0x0300.
- Reset asserted at T+4 of a sweep:
  - From T+5, o_clk_en = 0 and all outputs are 0.
  - The next tick's voice-0 o_phase = 0x0000 with o_gate = 0.
